// File: rtl/pin_verifier_pkg.sv
// -----------------------------------------------------------------------------
// pin_verifier_pkg
// Shared definitions for the PIN reader/checker and the PIN configuration
// block: stored PIN field widths, the lockout timer width and the checker
// state encoding.
// -----------------------------------------------------------------------------
package pin_verifier_pkg;

    localparam int PIN_A_W = 4;
    localparam int PIN_B_W = 3;

    // Wide enough for the longest lockout duration.
    localparam int TIMER_W = 32;

    typedef enum logic [2:0] {
        S_WAIT_CONFIG = 3'd0,
        S_IDLE        = 3'd1,
        S_CHECK       = 3'd2,
        S_UNLOCKED    = 3'd3,
        S_FAIL        = 3'd4,
        S_LOCKOUT     = 3'd5
    } state_t;

endpackage

// File: rtl/pin_verifier_timer.sv
// -----------------------------------------------------------------------------
// pin_verifier_timer
// Loadable down-counter used for the error hold and lockout periods.
// The count stops at zero; Zero flags the terminal value.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset_n    asynchronous active-low reset (count cleared)
//   Load       load Load_Value this cycle (has priority over Enable)
//   Load_Value value to load
//   Enable     decrement by one when the count is non-zero
//   Zero       high while the count is zero
// -----------------------------------------------------------------------------
module pin_verifier_timer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_Value,
    input  logic             Enable,
    output logic             Zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (Load) begin
            count <= Load_Value;
        end else if (Enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign Zero = (count == '0);

endmodule

// File: rtl/pin_verifier.sv
// -----------------------------------------------------------------------------
// pin_verifier
// Reader/checker side of the PIN interface. Waits for the configuration block
// to publish a valid PIN, then compares user guesses (captured on a rising
// edge of Enter) against it. A wrong guess holds Error for ERROR_CYCLES; the
// last allowed wrong guess forces a LOCKOUT_CYCLES lockout. A correct guess
// unlocks until the next Enter press relocks.
//
// Ports:
//   Clk               system clock, rising edge
//   Reset_n           asynchronous active-low reset
//   Config_Done       stored PIN valid (Done_Register of the config block)
//   A_Pin, B_Pin      stored PIN parts A and B
//   Enter             guess / relock button (level, already synchronised)
//   Switches_A_Guess  guess part A
//   Switches_B_Guess  guess part B
//   Unlocked          high while unlocked
//   Error             high while holding the wrong-guess indication
//   Locked_Out        high while locked out
//   Attempts_Left     remaining wrong guesses before lockout
//   Ready             high while a guess will be accepted
//
// Outputs are registered decodes of the state and attempt counter, so they
// trail the state by one cycle: a rise of Enter sampled at edge N is checked
// during cycle N+1 and the result shows after edge N+2.
// MAX_ATTEMPTS must lie in 1..3 and LOCKOUT_CYCLES below 2^32.
// -----------------------------------------------------------------------------
module pin_verifier
    import pin_verifier_pkg::*;
#(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int ERROR_CYCLES   = 25_000_000,
    parameter int LOCKOUT_CYCLES = 250_000_000
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Config_Done,
    input  logic [PIN_A_W-1:0] A_Pin,
    input  logic [PIN_B_W-1:0] B_Pin,
    input  logic               Enter,
    input  logic [PIN_A_W-1:0] Switches_A_Guess,
    input  logic [PIN_B_W-1:0] Switches_B_Guess,
    output logic               Unlocked,
    output logic               Error,
    output logic               Locked_Out,
    output logic [1:0]         Attempts_Left,
    output logic               Ready
);

    localparam logic [1:0]         MAX_ATT   = 2'(MAX_ATTEMPTS);
    localparam logic [TIMER_W-1:0] ERR_LOAD  = TIMER_W'(ERROR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         attempts;
    logic [1:0]         attempts_nxt;
    logic               enter_old;
    logic               enter_rise;
    logic [PIN_A_W-1:0] guess_a;
    logic [PIN_B_W-1:0] guess_b;
    logic               guess_load;
    logic               guess_match;
    logic               config_drop;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_val;
    logic               timer_en;
    logic               timer_zero;

    assign enter_rise  = Enter & ~enter_old;
    assign guess_match = ({guess_a, guess_b} == {A_Pin, B_Pin});

    // Losing the stored PIN outside WAIT_CONFIG overrides every transition.
    assign config_drop = ~Config_Done & (state != S_WAIT_CONFIG);

    pin_verifier_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Load       (timer_load),
        .Load_Value (timer_load_val),
        .Enable     (timer_en),
        .Zero       (timer_zero)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        attempts_nxt   = attempts;
        guess_load     = 1'b0;
        timer_load     = 1'b0;
        timer_load_val = '0;
        timer_en       = 1'b0;

        if (config_drop) begin
            state_nxt    = S_WAIT_CONFIG;
            attempts_nxt = MAX_ATT;
            timer_load   = 1'b1;
        end else begin
            unique case (state)
                S_WAIT_CONFIG: begin
                    if (Config_Done) begin
                        state_nxt = S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (enter_rise) begin
                        guess_load = 1'b1;
                        state_nxt  = S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (guess_match) begin
                        state_nxt    = S_UNLOCKED;
                        attempts_nxt = MAX_ATT;
                    end else if (attempts > 2'd1) begin
                        state_nxt      = S_FAIL;
                        attempts_nxt   = attempts - 2'd1;
                        timer_load     = 1'b1;
                        timer_load_val = ERR_LOAD;
                    end else begin
                        state_nxt      = S_LOCKOUT;
                        attempts_nxt   = 2'd0;
                        timer_load     = 1'b1;
                        timer_load_val = LOCK_LOAD;
                    end
                end

                S_UNLOCKED: begin
                    if (enter_rise) begin
                        state_nxt = S_IDLE;
                    end
                end

                S_FAIL: begin
                    if (timer_zero) begin
                        state_nxt = S_IDLE;
                    end else begin
                        timer_en = 1'b1;
                    end
                end

                S_LOCKOUT: begin
                    if (timer_zero) begin
                        state_nxt    = S_IDLE;
                        attempts_nxt = MAX_ATT;
                    end else begin
                        timer_en = 1'b1;
                    end
                end

                default: begin
                    state_nxt    = S_WAIT_CONFIG;
                    attempts_nxt = MAX_ATT;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State, counters and captured guess
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_WAIT_CONFIG;
            attempts  <= MAX_ATT;
            enter_old <= 1'b0;
            guess_a   <= '0;
            guess_b   <= '0;
        end else begin
            state     <= state_nxt;
            attempts  <= attempts_nxt;
            enter_old <= Enter;
            if (guess_load) begin
                guess_a <= Switches_A_Guess;
                guess_b <= Switches_B_Guess;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered output decode
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Unlocked      <= 1'b0;
            Error         <= 1'b0;
            Locked_Out    <= 1'b0;
            Ready         <= 1'b0;
            Attempts_Left <= MAX_ATT;
        end else if (config_drop) begin
            // Clear indications in the same cycle the state falls back.
            Unlocked      <= 1'b0;
            Error         <= 1'b0;
            Locked_Out    <= 1'b0;
            Ready         <= 1'b0;
            Attempts_Left <= MAX_ATT;
        end else begin
            Unlocked      <= (state == S_UNLOCKED);
            Error         <= (state == S_FAIL);
            Locked_Out    <= (state == S_LOCKOUT);
            Ready         <= (state == S_IDLE);
            Attempts_Left <= attempts;
        end
    end

endmodule

// File: tb/tb_pin_verifier.sv
// -----------------------------------------------------------------------------
// tb_pin_verifier
// Self-checking bench for pin_verifier with short error/lockout periods.
// A table of {inputs, expected outputs} records is applied one per clock;
// each expectation is queued when its inputs are driven and compared after
// the edge that samples them. Hand-written sequences cover reset during
// lockout.
// -----------------------------------------------------------------------------
module tb_pin_verifier;

    localparam int MAX_ATT = 3;
    localparam int ERR_CYC = 4;
    localparam int LCK_CYC = 10;

    localparam logic [3:0] PA = 4'hA;
    localparam logic [2:0] PB = 3'h5;
    localparam logic [3:0] WA = 4'h3;

    logic       Clk;
    logic       Reset_n;
    logic       Config_Done;
    logic [3:0] A_Pin;
    logic [2:0] B_Pin;
    logic       Enter;
    logic [3:0] Switches_A_Guess;
    logic [2:0] Switches_B_Guess;
    logic       Unlocked;
    logic       Error;
    logic       Locked_Out;
    logic [1:0] Attempts_Left;
    logic       Ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       cd;
        logic       en;
        logic [3:0] ga;
        logic [2:0] gb;
        logic [5:0] exp;   // {Unlocked, Error, Locked_Out, Attempts_Left, Ready}
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] exp_q[$];

    pin_verifier #(
        .MAX_ATTEMPTS   (MAX_ATT),
        .ERROR_CYCLES   (ERR_CYC),
        .LOCKOUT_CYCLES (LCK_CYC)
    ) dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .Config_Done      (Config_Done),
        .A_Pin            (A_Pin),
        .B_Pin            (B_Pin),
        .Enter            (Enter),
        .Switches_A_Guess (Switches_A_Guess),
        .Switches_B_Guess (Switches_B_Guess),
        .Unlocked         (Unlocked),
        .Error            (Error),
        .Locked_Out       (Locked_Out),
        .Attempts_Left    (Attempts_Left),
        .Ready            (Ready)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [5:0] o(logic u, logic e, logic l, logic [1:0] al, logic r);
        return {u, e, l, al, r};
    endfunction

    function automatic void add(logic cd, logic en, logic [3:0] ga, logic [2:0] gb,
                                logic [5:0] exp);
        vec_t v;
        v.cd  = cd;
        v.en  = en;
        v.ga  = ga;
        v.gb  = gb;
        v.exp = exp;
        vecs.push_back(v);
    endfunction

    function automatic logic [5:0] outs();
        return {Unlocked, Error, Locked_Out, Attempts_Left, Ready};
    endfunction

    task automatic check(string name, logic [5:0] act, logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got U/E/L/AL/R=%b required %b", name, act, exp);
        end
    endtask

    // Drive inputs now (at a falling edge), let one rising edge pass,
    // return at the next falling edge.
    task automatic step(logic cd, logic en, logic [3:0] ga, logic [2:0] gb);
        Config_Done      = cd;
        Enter            = en;
        Switches_A_Guess = ga;
        Switches_B_Guess = gb;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        logic [5:0] z3, r3, r2, r1, u3, e2, e1, l0, z2, z1;
        logic [5:0] exp;

        z3 = o(0, 0, 0, 2'd3, 0);
        z2 = o(0, 0, 0, 2'd2, 0);
        z1 = o(0, 0, 0, 2'd1, 0);
        r3 = o(0, 0, 0, 2'd3, 1);
        r2 = o(0, 0, 0, 2'd2, 1);
        r1 = o(0, 0, 0, 2'd1, 1);
        u3 = o(1, 0, 0, 2'd3, 0);
        e2 = o(0, 1, 0, 2'd2, 0);
        e1 = o(0, 1, 0, 2'd1, 0);
        l0 = o(0, 0, 1, 2'd0, 0);

        // Configuration comes up, correct guess unlocks, press relocks.
        add(1, 0, 0,  0,  z3);
        add(1, 0, 0,  0,  r3);
        add(1, 1, PA, PB, r3);
        add(1, 0, 0,  0,  z3);
        add(1, 0, 0,  0,  u3);
        add(1, 1, 0,  0,  u3);
        add(1, 0, 0,  0,  r3);
        // First wrong guess; switches changed to the right PIN during CHECK,
        // presses during the error hold are ignored.
        add(1, 1, WA, PB, r3);
        add(1, 0, PA, PB, z3);
        add(1, 1, PA, PB, e2);
        add(1, 0, PA, PB, e2);
        add(1, 1, PA, PB, e2);
        add(1, 0, PA, PB, e2);
        add(1, 0, PA, PB, r2);
        // Second wrong guess.
        add(1, 1, WA, PB, r2);
        add(1, 0, WA, PB, z2);
        for (int k = 0; k < ERR_CYC; k++) add(1, 0, WA, PB, e1);
        add(1, 0, WA, PB, r1);
        // Third wrong guess -> lockout; correct presses during it are ignored.
        add(1, 1, WA, PB, r1);
        add(1, 0, WA, PB, z1);
        for (int k = 0; k < LCK_CYC; k++)
            add(1, (k == 1 || k == 3 || k == 5), PA, PB, l0);
        add(1, 0, PA, PB, r3);
        // Enter held for 20 cycles: exactly one unlock, no relock.
        for (int k = 0; k < 20; k++)
            add(1, 1, PA, PB, (k == 0) ? r3 : (k == 1) ? z3 : u3);
        add(1, 0, PA, PB, u3);
        add(1, 1, PA, PB, u3);
        add(1, 0, PA, PB, r3);
        // Unlock, then drop Config_Done; a press in WAIT_CONFIG is not queued.
        add(1, 1, PA, PB, r3);
        add(1, 0, PA, PB, z3);
        add(1, 0, PA, PB, u3);
        add(0, 0, PA, PB, z3);
        add(0, 1, PA, PB, z3);
        add(1, 1, PA, PB, z3);
        add(1, 0, PA, PB, r3);
        add(1, 0, PA, PB, r3);
        // Config_Done dropped mid-error reloads the attempt count.
        add(1, 1, WA, PB, r3);
        add(1, 0, WA, PB, z3);
        add(1, 0, WA, PB, e2);
        add(0, 0, WA, PB, z3);
        add(1, 0, WA, PB, z3);
        add(1, 0, WA, PB, r3);

        // Reset state.
        Reset_n          = 1'b0;
        Config_Done      = 1'b0;
        A_Pin            = PA;
        B_Pin            = PB;
        Enter            = 1'b0;
        Switches_A_Guess = '0;
        Switches_B_Guess = '0;
        repeat (3) @(negedge Clk);
        check("reset_state", outs(), z3);
        Reset_n = 1'b1;
        step(0, 0, 0, 0);
        check("wait_config_idle", outs(), z3);

        // Table: queue each expectation as its inputs are driven.
        foreach (vecs[i]) begin
            Config_Done      = vecs[i].cd;
            Enter            = vecs[i].en;
            Switches_A_Guess = vecs[i].ga;
            Switches_B_Guess = vecs[i].gb;
            exp_q.push_back(vecs[i].exp);
            @(posedge Clk);
            @(negedge Clk);
            exp = exp_q.pop_front();
            check($sformatf("vec%0d", i), outs(), exp);
        end

        // Three wrong guesses into lockout, then reset mid-lockout.
        for (int g = 0; g < 3; g++) begin
            step(1, 1, WA, PB);
            repeat (6) step(1, 0, WA, PB);
        end
        check("lockout_before_reset", outs(), l0);
        Reset_n = 1'b0;
        #1;
        check("async_reset_in_lockout", outs(), z3);
        @(negedge Clk);
        check("held_reset", outs(), z3);
        Reset_n = 1'b1;
        step(1, 0, PA, PB);
        step(1, 0, PA, PB);
        check("ready_after_reset", outs(), r3);
        // Lockout was not remembered: a correct guess unlocks at once.
        step(1, 1, PA, PB);
        step(1, 0, PA, PB);
        step(1, 0, PA, PB);
        check("unlock_after_reset", outs(), u3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pin_verifier.md
Name: pin_verifier

Overview:
- Reader/checker side of the PIN interface: consumes the stored A_Pin/B_Pin and Done_Register from the PIN configuration block.
- Compares user-entered guesses against the stored PIN and drives unlock/error indication.
- Enforces a limited attempt count with a timed lockout.
- Sits between the configuration block and the board LEDs/displays.

Parameters:
MAX_ATTEMPTS, 3, wrong guesses allowed before lockout; legal range 1..3.
ERROR_CYCLES, 25_000_000, number of cycles Error is held after a wrong guess.
LOCKOUT_CYCLES, 250_000_000, lockout duration in cycles; must be < 2^32.

Ports:
Clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
Config_Done  input  1  Done_Register from the configuration block; high = PIN valid
A_Pin  input  4  stored PIN part A
B_Pin  input  3  stored PIN part B
Enter  input  1  guess/relock button, level, already synchronised
Switches_A_Guess  input  4  guess part A
Switches_B_Guess  input  3  guess part B
Unlocked  output  1  high while in UNLOCKED
Error  output  1  high while in FAIL
Locked_Out  output  1  high while in LOCKOUT
Attempts_Left  output  2  remaining attempts
Ready  output  1  high while in IDLE (guess accepted)

Behaviour:
- Reset (Reset_n=0, async) sets:
  - state WAIT_CONFIG;
  - Unlocked, Error, Locked_Out and Ready = 0;
  - Attempts_Left = MAX_ATTEMPTS;
  - Enter_Old = 0, timer = 0, guess registers = 0.
- Edge detect: Enter_Rise = Enter & !Enter_Old. Enter_Old is updated every cycle in every state.
- All outputs are registered and decoded from the state/counters.
- States and transitions:
  - WAIT_CONFIG: Enter is ignored. Moves to IDLE on the first cycle Config_Done = 1.
  - IDLE: Ready = 1. On Enter_Rise, capture Switches_A_Guess/Switches_B_Guess into the guess registers and go to CHECK.
  - CHECK: one cycle. Compare the registered guess with {A_Pin, B_Pin}.
    - Match: go to UNLOCKED and reload Attempts_Left = MAX_ATTEMPTS.
    - Mismatch with Attempts_Left > 1: decrement Attempts_Left, load timer = ERROR_CYCLES-1, go to FAIL.
    - Mismatch with Attempts_Left = 1: set Attempts_Left = 0, load timer = LOCKOUT_CYCLES-1, go to LOCKOUT.
  - UNLOCKED: Enter_Rise relocks and returns to IDLE. Attempts_Left is unchanged.
  - FAIL: timer decrements each cycle; at timer = 0 go to IDLE. Enter is ignored.
  - LOCKOUT: timer decrements each cycle; at timer = 0 reload Attempts_Left = MAX_ATTEMPTS and go to IDLE. Enter is ignored.
- Latency: Enter_Rise is sampled at edge N; CHECK holds during cycle N+1; the result outputs are visible after edge N+2.
- Enter held high produces no repeat action; a new press requires Enter to go low first.
- Enter_Rise arriving while Ready = 0 (CHECK, FAIL, LOCKOUT, WAIT_CONFIG) is discarded and not queued.
- Config_Done low in any state other than WAIT_CONFIG:
  - go to WAIT_CONFIG next cycle;
  - clear all indications;
  - reload Attempts_Left = MAX_ATTEMPTS;
  - this has priority over all other transitions.
- Changing the switches after capture has no effect on the comparison in progress.
- Reset asserted mid-FAIL or mid-LOCKOUT aborts the timer immediately. The lockout is not remembered across reset.

Decomposition:
- Shared package holds:
  - the state encoding constants (WAIT_CONFIG, IDLE, CHECK, UNLOCKED, FAIL, LOCKOUT; 3-bit);
  - the PIN widths PIN_A_W = 4 and PIN_B_W = 3, which the configuration block also uses.
- No sub-module is required. The down-counter timer may optionally be split out as pin_timer (load, enable, zero flag).

Test Plan:
- Reset then Config_Done=1 with A_Pin=4'hA, B_Pin=3'h5 -> Ready=1 one cycle later, Attempts_Left=3, all other outputs 0.
- Guess A=4'hA, B=3'h5 plus Enter pulse -> Unlocked=1 exactly 2 edges after the rising-edge sample, Attempts_Left=3; a second Enter pulse -> Unlocked=0, Ready=1.
- With ERROR_CYCLES=4, guess A=4'h3 -> Error=1 for exactly 4 cycles, Attempts_Left=2, then Ready=1; Enter pulses during FAIL have no effect.
- With LOCKOUT_CYCLES=10, three wrong guesses -> Locked_Out=1 for 10 cycles, Attempts_Left=0, then back to 3 with Ready=1; a correct guess during lockout is ignored.
- Enter held high for 20 cycles with a correct guess -> exactly one unlock; release and re-press -> relock.
- Reset_n low mid-LOCKOUT -> all outputs 0 and Attempts_Left=3 immediately; Config_Done dropped while UNLOCKED -> Unlocked=0 and WAIT_CONFIG on the next cycle.
